// File: rtl/red_pitaya_exp_in.sv
// rtl/red_pitaya_exp_in.sv - expansion input conditioner: sync, optional debounce (EXP_IN_DEBOUNCE_EN), edge IRQ, bus regs
module red_pitaya_exp_in #(
    parameter int          DWE     = 8,
    parameter logic [15:0] DEB_RST = 16'h0FFF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [DWE-1:0] exp_p_i,
    input  logic [DWE-1:0] exp_n_i,
    output logic [DWE-1:0] exp_p_dat_o,
    output logic [DWE-1:0] exp_n_dat_o,
    output logic           irq_o,
    input  logic [31:0]    sys_addr,
    input  logic [31:0]    sys_wdata,
    input  logic           sys_wen,
    input  logic           sys_ren,
    output logic [31:0]    sys_rdata,
    output logic           sys_err,
    output logic           sys_ack
);

    localparam int DW2 = 2 * DWE;

    logic [DW2-1:0] sync_meta;
    logic [DW2-1:0] sync;
    logic [DW2-1:0] deb;
    logic [DW2-1:0] deb_q;
    logic [DW2-1:0] rise_en;
    logic [DW2-1:0] fall_en;
    logic [DW2-1:0] pending;
    logic [DW2-1:0] set_evt;
    logic [DW2-1:0] clr_evt;
    logic [15:0]    per_rd;
    logic [31:0]    rd_mux;
    logic           wr_per;
    logic           wr_rise;
    logic           wr_fall;
    logic           wr_pend;

    wire [19:0] addr = sys_addr[19:0];
    wire unused_bits = ^{sys_addr[31:20], sys_wdata[31:DW2]};

    always_comb begin
        wr_per  = 1'b0;
        wr_rise = 1'b0;
        wr_fall = 1'b0;
        wr_pend = 1'b0;
        if (sys_wen) begin
            case (addr)
                20'h00008: wr_per  = 1'b1;
                20'h0000C: wr_rise = 1'b1;
                20'h00010: wr_fall = 1'b1;
                20'h00014: wr_pend = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= {exp_n_i, exp_p_i};
            sync      <= sync_meta;
        end
    end

`ifdef EXP_IN_DEBOUNCE_EN
    logic [15:0]    per;
    logic [15:0]    cnt;
    logic           tick;
    logic [DW2-1:0] hist0;
    logic [DW2-1:0] hist1;
    logic [DW2-1:0] hist2;

    assign tick   = (cnt == per);
    assign per_rd = per;

    // hist only moves on ticks, so deb follows one cycle after the tick that settles it
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            per   <= DEB_RST;
            cnt   <= '0;
            hist0 <= '0;
            hist1 <= '0;
            hist2 <= '0;
            deb   <= '0;
        end else begin
            if (wr_per)
                per <= sys_wdata[15:0];
            if (wr_per || tick)
                cnt <= '0;
            else
                cnt <= cnt + 16'd1;
            if (tick) begin
                hist0 <= sync;
                hist1 <= hist0;
                hist2 <= hist1;
            end
            deb <= (hist0 & hist1 & hist2) | (deb & (hist0 | hist1 | hist2));
        end
    end
`else
    wire unused_deb_rst = ^DEB_RST;

    assign per_rd = 16'h0000;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            deb <= '0;
        else
            deb <= sync;
    end
`endif

    assign set_evt = (deb & ~deb_q & rise_en) | (~deb & deb_q & fall_en);
    assign clr_evt = wr_pend ? sys_wdata[DW2-1:0] : '0;

    // a new event in the same cycle as its W1C keeps the bit set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            deb_q   <= '0;
            rise_en <= '0;
            fall_en <= '0;
            pending <= '0;
            irq_o   <= 1'b0;
        end else begin
            deb_q   <= deb;
            if (wr_rise)
                rise_en <= sys_wdata[DW2-1:0];
            if (wr_fall)
                fall_en <= sys_wdata[DW2-1:0];
            pending <= (pending & ~clr_evt) | set_evt;
            irq_o   <= |pending;
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        case (addr)
            20'h00000: rd_mux = 32'(deb[DWE-1:0]);
            20'h00004: rd_mux = 32'(deb[DW2-1:DWE]);
            20'h00008: rd_mux = 32'(per_rd);
            20'h0000C: rd_mux = 32'(rise_en);
            20'h00010: rd_mux = 32'(fall_en);
            20'h00014: rd_mux = 32'(pending);
            20'h00018: rd_mux = 32'(sync);
            default:   rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sys_ack   <= 1'b0;
            sys_rdata <= 32'h0;
        end else begin
            sys_ack   <= sys_wen | sys_ren;
            sys_rdata <= sys_ren ? rd_mux : 32'h0;
        end
    end

    assign exp_p_dat_o = deb[DWE-1:0];
    assign exp_n_dat_o = deb[DW2-1:DWE];
    assign sys_err     = 1'b0;

endmodule

// File: tb/tb_red_pitaya_exp_in.sv
// tb/tb_red_pitaya_exp_in.sv - directed scoreboard bench for red_pitaya_exp_in
module tb_red_pitaya_exp_in;

    localparam int DWE = 8;
`ifdef EXP_IN_DEBOUNCE_EN
    localparam int          LAT     = 6;
    localparam logic [31:0] PER_RST = 32'h0000_0FFF;
    localparam logic [31:0] P3_LATE = 32'h0;
`else
    localparam int          LAT     = 3;
    localparam logic [31:0] PER_RST = 32'h0;
    localparam logic [31:0] P3_LATE = 32'h8;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [DWE-1:0] exp_p;
    logic [DWE-1:0] exp_n;
    logic [DWE-1:0] p_dat;
    logic [DWE-1:0] n_dat;
    logic           irq;
    logic [31:0]    addr;
    logic [31:0]    wdata;
    logic           wen;
    logic           ren;
    logic [31:0]    rdata;
    logic           err;
    logic           ack;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    red_pitaya_exp_in #(.DWE(DWE), .DEB_RST(16'h0FFF)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .exp_p_i     (exp_p),
        .exp_n_i     (exp_n),
        .exp_p_dat_o (p_dat),
        .exp_n_dat_o (n_dat),
        .irq_o       (irq),
        .sys_addr    (addr),
        .sys_wdata   (wdata),
        .sys_wen     (wen),
        .sys_ren     (ren),
        .sys_rdata   (rdata),
        .sys_err     (err),
        .sys_ack     (ack)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $error("FAIL %s: observed %h with no expected value queued", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        sb.push_back(exp);
        cmp(tag, obs);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        step(1);
        wen   = 1'b0;
        chk("wr_ack", 32'(ack), 32'h1);
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        sb.push_back(exp);
        addr = a;
        ren  = 1'b1;
        step(1);
        ren  = 1'b0;
        cmp(tag, rdata);
        chk({tag, "_ack"}, 32'(ack), 32'h1);
    endtask

    initial begin
        rst   = 1'b1;
        exp_p = '0;
        exp_n = '0;
        addr  = '0;
        wdata = '0;
        wen   = 1'b0;
        ren   = 1'b0;
        step(3);
        chk("rst_p_dat", 32'(p_dat), 32'h0);
        chk("rst_n_dat", 32'(n_dat), 32'h0);
        chk("rst_irq",   32'(irq),   32'h0);
        chk("rst_ack",   32'(ack),   32'h0);
        chk("rst_rdata", rdata,      32'h0);
        chk("rst_err",   32'(err),   32'h0);
        rst = 1'b0;
        step(1);

        bus_read("per_rst", 32'h08, PER_RST);
        bus_read("unmapped", 32'h40, 32'h0);

        // latency of a clean rising pin with the fastest prescaler
        bus_write(32'h08, 32'h0);
        step(4);
        exp_p = 8'h01;
        step(LAT - 1);
        chk("lat_early", 32'(p_dat), 32'h0);
        step(1);
        chk("lat_exact", 32'(p_dat), 32'h1);
        exp_p = 8'h00;
        step(LAT + 2);
        chk("lat_fall", 32'(p_dat), 32'h0);
        bus_read("pend_disabled", 32'h14, 32'h0);

        // rise-only enable: rise latches, fall does not
        bus_write(32'h0C, 32'h1);
        bus_write(32'h10, 32'h0);
        exp_p = 8'h01;
        step(LAT + 2);
        chk("irq_rise", 32'(irq), 32'h1);
        bus_read("pend_rise", 32'h14, 32'h1);
        exp_p = 8'h00;
        step(LAT + 3);
        chk("p_dat_low", 32'(p_dat), 32'h0);
        bus_read("pend_sticky", 32'h14, 32'h1);
        bus_write(32'h14, 32'h1);
        chk("irq_lag", 32'(irq), 32'h1);
        step(1);
        chk("irq_clr", 32'(irq), 32'h0);
        bus_read("pend_clr", 32'h14, 32'h0);

        // W1C lands on the same edge the new rise sets the bit
        exp_p = 8'h01;
        step(LAT);
        bus_write(32'h14, 32'h1);
        bus_read("set_wins", 32'h14, 32'h1);
        chk("set_wins_irq", 32'(irq), 32'h1);
        bus_write(32'h14, 32'h1);
        exp_p = 8'h00;
        step(LAT + 3);
        bus_read("no_fall_evt", 32'h14, 32'h0);

        bus_write(32'h0C, 32'h400);
`ifdef EXP_IN_DEBOUNCE_EN
        bus_write(32'h08, 32'h3);
        step(8);
        exp_n = 8'h04;
        step(1);
        exp_n = 8'h00;
        step(40);
        chk("glitch_n_dat", 32'(n_dat), 32'h0);
        bus_read("glitch_pend", 32'h14, 32'h0);
`endif
        exp_n = 8'h04;
        step(30);
        chk("held_n_dat", 32'(n_dat), 32'h4);
        bus_read("rd_deb_n", 32'h04, 32'h4);
        bus_read("pend_n2", 32'h14, 32'h400);
        bus_read("rd_sync", 32'h18, 32'h400);
        chk("irq_n2", 32'(irq), 32'h1);

        // reset in the middle of a debounce, coincident with a read
        exp_p = 8'h08;
        step(3);
        addr = 32'h18;
        ren  = 1'b1;
        rst  = 1'b1;
        step(1);
        ren  = 1'b0;
        rst  = 1'b0;
        chk("mid_rst_p_dat", 32'(p_dat), 32'h0);
        chk("mid_rst_n_dat", 32'(n_dat), 32'h0);
        chk("mid_rst_irq",   32'(irq),   32'h0);
        chk("mid_rst_ack",   32'(ack),   32'h0);
        chk("mid_rst_rdata", rdata,      32'h0);
        bus_read("per_after_rst", 32'h08, PER_RST);
        bus_read("rise_after_rst", 32'h0C, 32'h0);
        bus_read("pend_after_rst", 32'h14, 32'h0);
        step(5);
        bus_read("deb_p_after_rst", 32'h00, P3_LATE);
        bus_read("pend_no_evt", 32'h14, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/red_pitaya_exp_in.md
RED_PITAYA_EXP_IN -- requirements
Module: red_pitaya_exp_in

Interface
REQ-001 SHALL have parameter DWE, default 8, meaning bits per expansion bank (P and N).
REQ-002 SHALL have parameter DEB_RST, default 16'h0FFF, meaning reset value of the debounce prescaler period.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_i  in  1  system clock.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port exp_p_i  in  DWE  raw asynchronous P-bank pins.
REQ-007 SHALL have port exp_n_i  in  DWE  raw asynchronous N-bank pins.
REQ-008 SHALL have port exp_p_dat_o  out  DWE  conditioned P data, feeding the housekeeping block's exp_p_dat_i.
REQ-009 SHALL have port exp_n_dat_o  out  DWE  conditioned N data, feeding the housekeeping block's exp_n_dat_i.
REQ-010 SHALL have port irq_o  out  1  level interrupt, high while any pending bit is set.
REQ-011 SHALL have ports sys_addr in 32, sys_wdata in 32, sys_wen in 1, sys_ren in 1, sys_rdata out 32, sys_err out 1 and sys_ack out 1, forming the standard system bus.

Function
REQ-012 SHALL pass each pin bit through a 2-flop synchronizer; the vector {N,P} (2*DWE bits, P in low half) is "sync".
REQ-013 SHALL run a 16-bit prescaler counting 0..PER and pulse "tick" for one cycle when count==PER; PER=0 gives tick every cycle.
REQ-014 SHALL, on each tick, shift each sync bit into a per-bit 3-sample history.
REQ-015 SHALL update a debounced bit one cycle after a tick leaves its 3 samples all equal and different from the current debounced value; mixed samples hold the value.
REQ-016 SHALL drive exp_p_dat_o/exp_n_dat_o directly from the debounced register.
REQ-017 SHALL set pending[i] the cycle after debounced[i] rises while rise_en[i]=1, or falls while fall_en[i]=1.
REQ-018 SHALL keep pending bits sticky until cleared by writing 1 to that bit; a set event in the same cycle as a clear SHALL win (bit stays 1).
REQ-019 SHALL register irq_o = OR of pending, one cycle after pending changes.
REQ-020 SHALL decode sys_addr[19:0] as follows: 0x00 debounced P (RO); 0x04 debounced N (RO); 0x08 PER[15:0] (RW); 0x0C rise_en[2*DWE-1:0] (RW); 0x10 fall_en (RW); 0x14 pending (R/W1C); 0x18 sync (RO).
REQ-021 SHALL reset the prescaler count to 0 in the cycle following a write to 0x08.
REQ-022 SHALL assert sys_ack one cycle after (sys_wen|sys_ren) for any address, with rdata valid in the same cycle; unmapped reads SHALL return 0, and writes to RO or unmapped addresses SHALL be ignored.
REQ-023 SHALL hold sys_err at 0.

Reset
REQ-024 SHALL, while rst_i=1 at a clock edge, clear synchronizers, histories, debounced, pending, rise_en, fall_en, prescaler count, irq_o, sys_ack and sys_rdata to 0, and load PER=DEB_RST.
REQ-025 SHALL abort an in-progress debounce on reset; after release, pins high at reset produce no edge event until they are debounced as 1 (a rise, pending only if enabled).

Configuration
REQ-026 SHALL, with macro EXP_IN_DEBOUNCE_EN defined, implement the prescaler and histories as in REQ-013..REQ-015.
REQ-027 SHALL, without EXP_IN_DEBOUNCE_EN, set debounced = sync registered one cycle later, omit the prescaler, read 0x08 as 0 and ignore writes to it; edge/pending logic is unchanged.

Verification
REQ-028 SHALL cover: PER=0, exp_p_i[0] 0->1 -> exp_p_dat_o[0]=1 exactly 6 cycles after the pin change (2 sync + 3 ticks + 1).
REQ-029 SHALL cover: PER=3, 1-cycle glitch on exp_n_i[2] -> exp_n_dat_o unchanged, pending stays 0.
REQ-030 SHALL cover: rise_en=0x0001, fall_en=0, pin P0 rises and falls -> pending=0x0001 and irq_o=1 after the rise only; write 0x1 to 0x14 -> pending=0, irq_o=0 one cycle later.
REQ-031 SHALL cover: W1C to 0x14 in the same cycle as a new rise event on the same bit -> pending bit remains 1.
REQ-032 SHALL cover: read 0x08 after reset -> 0x00000FFF with sys_ack one cycle after sys_ren; read 0x40 -> 0 with ack.
REQ-033 SHALL cover: rst_i asserted mid-debounce -> all outputs 0 the next cycle and PER=0x0FFF.
